vfpu_issue_arb: RTL and testbench

Shares one VFPU pipeline between NUM_REQ requesters. Each cycle, a round-robin arbiter grants at most one request. The granted operation (instruction plus three 32-bit single-precision operands) is registered onto the VFPU operand bus, and the requester ID is recorded in an in-order tag FIFO. Results return from the VFPU in issue order; each one is routed back to its owner. The block sits between the requester-side issue logic and the VFPU datapath, in place of the direct op_vld/operand drive.

---
 rtl/vfpu_issue_arb_pkg.sv | 6 +
 rtl/vfpu_issue_arb_if.sv | 32 +++
 rtl/vfpu_issue_arb_tag_fifo.sv | 36 +++
 rtl/vfpu_issue_arb.sv | 72 +++++++
 tb/tb_vfpu_issue_arb.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/vfpu_issue_arb_pkg.sv
// vfpu_issue_arb_pkg: shared constants and requester-ID type for the VFPU issue arbiter
package vfpu_issue_arb_pkg;
  localparam int VFPU_INS_W = 6;
  localparam int NUM_REQ_MAX = 8;
  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;
endpackage

// File: rtl/vfpu_issue_arb_if.sv
// vfpu_issue_arb_if: requester request/grant/response bus plus VFPU operand/result bus; master = requesters+VFPU, slave = arbiter
interface vfpu_issue_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int INS_W = vfpu_issue_arb_pkg::VFPU_INS_W
);
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ*INS_W-1:0] req_ins;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*32-1:0] req_c;
  logic [NUM_REQ-1:0] req_gnt;
  logic [INS_W-1:0] vfpu_ins;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] operand_c;
  logic op_vld;
  logic [31:0] res;
  logic res_rdy;
  logic [NUM_REQ-1:0] rsp_vld;
  logic [31:0] rsp_data;
  logic [$clog2(MAX_INFLIGHT):0] inflight;
  logic err_orphan;
  modport master (
    output req_vld, req_ins, req_a, req_b, req_c, res, res_rdy,
    input req_gnt, vfpu_ins, operand_a, operand_b, operand_c, op_vld, rsp_vld, rsp_data, inflight, err_orphan
  );
  modport slave (
    input req_vld, req_ins, req_a, req_b, req_c, res, res_rdy,
    output req_gnt, vfpu_ins, operand_a, operand_b, operand_c, op_vld, rsp_vld, rsp_data, inflight, err_orphan
  );
endinterface

// File: rtl/vfpu_issue_arb_tag_fifo.sv
// vfpu_issue_arb_tag_fifo: in-order requester-ID FIFO; ports clk, rst, push, pop, din, dout, empty, full, count
module vfpu_issue_arb_tag_fifo
  import vfpu_issue_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  req_id_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/vfpu_issue_arb.sv
// vfpu_issue_arb: round-robin issue of NUM_REQ requesters onto one VFPU with in-order result routing; ports clk, rst, bus (slave)
module vfpu_issue_arb
  import vfpu_issue_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int INS_W = VFPU_INS_W
) (
  input logic clk,
  input logic rst,
  vfpu_issue_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  logic [PW-1:0] rr_ptr, gnt_id, j, rr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0] count;
  logic full, empty, accept, retire;
  req_id_t head;
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!rst && !full && bus.req_vld[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        gnt_id = j;
      end
    end
  end
  assign accept = |gnt;
  assign retire = bus.res_rdy & ~empty;
  assign rr_nxt = (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign bus.req_gnt = gnt;
  assign bus.inflight = count;
  vfpu_issue_arb_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .pop(retire),
    .din(req_id_t'(gnt_id)),
    .dout(head),
    .empty(empty),
    .full(full),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      bus.op_vld <= 1'b0;
      bus.vfpu_ins <= '0;
      bus.operand_a <= '0;
      bus.operand_b <= '0;
      bus.operand_c <= '0;
      bus.rsp_vld <= '0;
      bus.rsp_data <= '0;
      bus.err_orphan <= 1'b0;
    end else begin
      rr_ptr <= accept ? rr_nxt : rr_ptr;
      bus.op_vld <= accept;
      bus.vfpu_ins <= accept ? bus.req_ins[int'(gnt_id)*INS_W +: INS_W] : bus.vfpu_ins;
      bus.operand_a <= accept ? bus.req_a[int'(gnt_id)*32 +: 32] : bus.operand_a;
      bus.operand_b <= accept ? bus.req_b[int'(gnt_id)*32 +: 32] : bus.operand_b;
      bus.operand_c <= accept ? bus.req_c[int'(gnt_id)*32 +: 32] : bus.operand_c;
      bus.rsp_vld <= retire ? NUM_REQ'(1) << head : '0;
      bus.rsp_data <= retire ? bus.res : bus.rsp_data;
      bus.err_orphan <= bus.err_orphan | (bus.res_rdy & empty);
    end
  end
endmodule

// File: tb/tb_vfpu_issue_arb.sv
// tb_vfpu_issue_arb: directed and random stimulus against a queue-based reference model of the issue arbiter
module tb_vfpu_issue_arb;
  localparam int N = 4;
  localparam int M = 8;
  localparam int IW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vfpu_issue_arb_if #(.NUM_REQ(N), .MAX_INFLIGHT(M), .INS_W(IW)) bus ();
  vfpu_issue_arb #(.NUM_REQ(N), .MAX_INFLIGHT(M), .INS_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [N-1:0] vld;
  logic [IW-1:0] ins [N];
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic [31:0] c [N];
  logic rr_in;
  logic [31:0] res_in;
  int rr;
  int q[$];
  int g;
  logic [N-1:0] obs_gnt;
  logic e_op, e_err;
  logic [IW-1:0] e_ins;
  logic [31:0] e_a, e_b, e_c, e_rd;
  logic [N-1:0] e_rsp;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    bus.req_vld = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_ins[i*IW +: IW] = ins[i];
      bus.req_a[i*32 +: 32] = a[i];
      bus.req_b[i*32 +: 32] = b[i];
      bus.req_c[i*32 +: 32] = c[i];
    end
    bus.res_rdy = rr_in;
    bus.res = res_in;
  endtask
  task automatic step();
    logic [N-1:0] eg;
    int o;
    drive();
    #1;
    g = -1;
    if (!rst && q.size() < M)
      for (int k = 0; k < N; k++)
        if (g < 0 && vld[(rr + k) % N]) g = (rr + k) % N;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_gnt = bus.req_gnt;
    chk("gnt", obs_gnt, eg);
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0;
      e_op = 0; e_ins = '0; e_a = '0; e_b = '0; e_c = '0;
      e_rsp = '0; e_rd = '0; e_err = 0;
    end else begin
      e_rsp = '0;
      if (rr_in) begin
        if (q.size() > 0) begin
          o = q.pop_front();
          e_rsp[o] = 1'b1;
          e_rd = res_in;
        end else e_err = 1;
      end
      e_op = g >= 0;
      if (g >= 0) begin
        q.push_back(g);
        rr = (g + 1) % N;
        e_ins = ins[g]; e_a = a[g]; e_b = b[g]; e_c = c[g];
      end
    end
    #1;
    chk("op_vld", bus.op_vld, e_op);
    chk("vfpu_ins", bus.vfpu_ins, e_ins);
    chk("operand_a", bus.operand_a, e_a);
    chk("operand_b", bus.operand_b, e_b);
    chk("operand_c", bus.operand_c, e_c);
    chk("rsp_vld", bus.rsp_vld, e_rsp);
    chk("rsp_data", bus.rsp_data, e_rd);
    chk("inflight", bus.inflight, 64'(q.size()));
    chk("err_orphan", bus.err_orphan, e_err);
  endtask
  initial begin
    vld = '0; rr_in = 0; res_in = '0; rr = 0;
    for (int i = 0; i < N; i++) begin
      ins[i] = IW'(i + 1); a[i] = 32'h1000 + i; b[i] = 32'h2000 + i; c[i] = 32'h3000 + i;
    end
    rst = 1; step(); step(); rst = 0;
    chk("reset_outputs", {bus.op_vld, bus.rsp_vld, bus.err_orphan, bus.inflight, bus.operand_a}, '0);
    vld = 4'b0100; ins[2] = 6'h03; a[2] = 32'h3F800000; b[2] = 32'h40000000; c[2] = 32'h0;
    step();
    chk("single_gnt", obs_gnt, 4'b0100);
    chk("single_issue", {bus.op_vld, bus.vfpu_ins, bus.operand_a, bus.operand_b}, {1'b1, 6'h03, 32'h3F800000, 32'h40000000});
    vld = '0;
    repeat (3) step();
    rr_in = 1; res_in = 32'h40400000; step(); rr_in = 0;
    chk("single_rsp", {bus.rsp_vld, bus.rsp_data}, {4'b0100, 32'h40400000});
    rst = 1; step(); rst = 0;
    vld = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_order", obs_gnt, 64'(1 << (i % 4)));
    end
    step();
    chk("fair_full_gnt", obs_gnt, 0);
    rst = 1; step(); rst = 0;
    vld = 4'b0010;
    repeat (9) step();
    chk("stall_gnt", obs_gnt, 0);
    chk("stall_inflight", bus.inflight, 8);
    rr_in = 1; res_in = 32'hCAFE0001; step(); rr_in = 0;
    chk("stall_gnt_at_retire", obs_gnt, 0);
    chk("stall_rsp", bus.rsp_vld, 4'b0010);
    step();
    chk("stall_resume", obs_gnt, 4'b0010);
    rst = 1; step(); rst = 0;
    vld = 4'b1101;
    repeat (3) step();
    vld = 4'b0010; rr_in = 1; res_in = 32'h12345678; step(); rr_in = 0;
    chk("simul_gnt", obs_gnt, 4'b0010);
    chk("simul_inflight", bus.inflight, 3);
    chk("simul_rsp", bus.rsp_vld, 4'b0001);
    vld = '0; rr_in = 1;
    repeat (3) step();
    step();
    chk("orphan_flag", bus.err_orphan, 1);
    chk("orphan_rsp", bus.rsp_vld, 0);
    rr_in = 0;
    repeat (3) step();
    chk("orphan_sticky", bus.err_orphan, 1);
    rst = 1; step(); rst = 0;
    vld = 4'b1111;
    repeat (5) step();
    vld = '0; rst = 1; step(); rst = 0;
    chk("midrst_outputs", {bus.op_vld, bus.rsp_vld, bus.err_orphan, bus.inflight, bus.operand_a}, '0);
    vld = 4'b1000; rr_in = 1; step(); rr_in = 0;
    chk("midrst_gnt", obs_gnt, 4'b1000);
    chk("midrst_orphan", bus.err_orphan, 1);
    vld = '0;
    rst = 1; step(); rst = 0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(2) == 0) begin
          vld[i] = 1'b1;
          ins[i] = IW'($urandom); a[i] = $urandom; b[i] = $urandom; c[i] = $urandom;
        end
      rr_in = $urandom_range(2) == 0;
      res_in = $urandom;
      rst = $urandom_range(199) == 0;
      step();
      if (g >= 0) vld[g] = 1'b0;
    end
    rst = 0; rr_in = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
